// File: rtl/interval_pkg.sv
// Shared encodings and sizing for the work/rest interval timer.
// Phase codes are also the values driven on the phase output.
package interval_pkg;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_WORK = 2'd1;
    localparam logic [1:0] PH_REST = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    localparam int DIV_W = 32;

    localparam int unsigned DEF_CLK_HZ  = 50_000_000;
    localparam int unsigned DEF_TICK_HZ = 1;

    // Cycles per countdown step; callers must keep the result >= 2.
    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    localparam int unsigned TICK_DIV = tick_div(DEF_CLK_HZ, DEF_TICK_HZ);

endpackage

// File: rtl/interval_tick_gen.sv
// Seconds divider: counts 0..DIV-1 while enabled and flags the wrap cycle.
// The tick is combinational so the FSM acts on the same edge the divider wraps.
module tick_gen
    import interval_pkg::*;
#(
    parameter int unsigned DIV = TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == DIV_W'(DIV - 1));
    assign tick = en && wrap;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Work/rest interval timer: counts programmed work and rest phases down in
// seconds over a programmed number of rounds; all outputs are registered.
module interval_timer
    import interval_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic [7:0] work_sec,
    input  logic [7:0] rest_sec,
    input  logic [3:0] rounds,
    output logic [7:0] T,
    output logic [1:0] phase,
    output logic [3:0] round_cnt,
    output logic       paused,
    output logic       done,
    output logic       buzz
);

    localparam int unsigned DIV = tick_div(CLK_HZ, TICK_HZ);

    logic [7:0] work_q;
    logic [7:0] rest_q;
    logic [3:0] rounds_q;

    logic [7:0] work_in;
    logic [3:0] rounds_in;
    logic       active;
    logic       start_ok;
    logic       pause_ok;
    logic       tick;
    logic       tick_ok;
    logic       last_sec;
    logic       enter;
    logic       div_en;

    // Priority abort > start > pause > tick is resolved here.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        work_in   = (work_sec == 8'd0) ? 8'd1 : work_sec;
        rounds_in = (rounds == 4'd0) ? 4'd1 : rounds;
        active    = (phase == PH_WORK) || (phase == PH_REST);
        start_ok  = start && !abort && !active;
        pause_ok  = pause && !abort && active;
        tick_ok   = tick && !abort && !pause_ok;
        last_sec  = (T == 8'd1);
        enter     = start_ok || (tick_ok && last_sec);
        div_en    = active && !paused;
    end

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (enter),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched settings are reset too, keeping X off the compare paths.
            work_q    <= 8'd0;
            rest_q    <= 8'd0;
            rounds_q  <= 4'd0;
            phase     <= PH_IDLE;
            T         <= 8'd0;
            round_cnt <= 4'd0;
            paused    <= 1'b0;
            done      <= 1'b0;
            buzz      <= 1'b0;
        end else begin
            buzz <= enter;
            if (abort) begin
                phase     <= PH_IDLE;
                T         <= 8'd0;
                round_cnt <= 4'd0;
                paused    <= 1'b0;
                done      <= 1'b0;
            end else if (start_ok) begin
                work_q    <= work_in;
                rest_q    <= rest_sec;
                rounds_q  <= rounds_in;
                phase     <= PH_WORK;
                T         <= work_in;
                round_cnt <= 4'd1;
                paused    <= 1'b0;
                done      <= 1'b0;
            end else begin
                if (pause_ok) begin
                    paused <= !paused;
                end
                if (tick_ok) begin
                    if (!last_sec) begin
                        T <= T - 8'd1;
                    end else if (phase == PH_WORK && round_cnt == rounds_q) begin
                        phase <= PH_DONE;
                        T     <= 8'd0;
                        done  <= 1'b1;
                    end else if (phase == PH_WORK && rest_q != 8'd0) begin
                        phase <= PH_REST;
                        T     <= rest_q;
                    end else begin
                        // End of REST, or WORK with no rest: next round.
                        phase     <= PH_WORK;
                        round_cnt <= round_cnt + 4'd1;
                        T         <= work_q;
                    end
                end
            end
        end
    end

endmodule
